// File: rtl/pkmc_sdram_access_sched.sv
// pkmc SDRAM access scheduler.
// Arbitrates requesters A and B and periodic refresh onto the single SDRAM FSM.
module pkmc_sdram_access_sched #(
  parameter int REF_PERIOD = 195,
  parameter int MAX_PEND   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       init_done_i,
  input  logic       req_a_i,
  input  logic       req_b_i,
  output logic       ack_a_o,
  output logic       ack_b_o,
  output logic       cmd_valid_o,
  output logic [1:0] cmd_sel_o,
  input  logic       cmd_done_i,
  output logic [2:0] ref_pend_o,
  output logic       ref_overrun_o
);

  typedef enum logic [1:0] {
    IDLE,
    CMD_A,
    CMD_B,
    CMD_REF
  } state_t;

  localparam logic [15:0] RELOAD   = 16'(REF_PERIOD - 1);
  localparam logic [2:0]  PEND_MAX = 3'(MAX_PEND);

  localparam logic [1:0] SEL_A   = 2'b00;
  localparam logic [1:0] SEL_B   = 2'b01;
  localparam logic [1:0] SEL_REF = 2'b10;

  state_t      state;
  state_t      state_nxt;
  logic [1:0]  sel;
  logic [1:0]  sel_nxt;
  logic        rr;
  logic        rr_nxt;
  logic [15:0] timer;
  logic [2:0]  pend;
  logic        ovr;
  logic        tick;
  logic        ref_done;

  assign tick     = init_done_i && (timer == 16'd0);
  assign ref_done = (state == CMD_REF) && cmd_done_i;

  // Refresh interval timer; parked at reload until init completes.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      timer <= RELOAD;
    end else if (!init_done_i || timer == 16'd0) begin
      timer <= RELOAD;
    end else begin
      timer <= timer - 16'd1;
    end
  end

  // Postponed-refresh count; a tick and a finished refresh cancel out.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend <= 3'd0;
    end else if (tick && !ref_done) begin
      if (pend != PEND_MAX) pend <= pend + 3'd1;
    end else if (ref_done && !tick) begin
      if (pend != 3'd0) pend <= pend - 3'd1;
    end
  end

  // Sticky overrun: a tick landed while the backlog was already full.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovr <= 1'b0;
    end else if (tick && pend == PEND_MAX) begin
      ovr <= 1'b1;
    end
  end

  // State, command select and round-robin pointer registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      sel   <= SEL_A;
      rr    <= 1'b0;
    end else begin
      state <= state_nxt;
      sel   <= sel_nxt;
      rr    <= rr_nxt;
    end
  end

  // Grant decision in IDLE; commands run until the FSM reports done.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    rr_nxt    = rr;
    unique case (state)
      IDLE: begin
        if (init_done_i) begin
          if (pend == PEND_MAX) begin
            state_nxt = CMD_REF;
            sel_nxt   = SEL_REF;
          end else if (req_a_i && req_b_i) begin
            state_nxt = rr ? CMD_B : CMD_A;
            sel_nxt   = rr ? SEL_B : SEL_A;
            rr_nxt    = ~rr;
          end else if (req_a_i) begin
            state_nxt = CMD_A;
            sel_nxt   = SEL_A;
          end else if (req_b_i) begin
            state_nxt = CMD_B;
            sel_nxt   = SEL_B;
          end else if (pend != 3'd0) begin
            state_nxt = CMD_REF;
            sel_nxt   = SEL_REF;
          end
        end
      end
      CMD_A, CMD_B, CMD_REF: begin
        if (cmd_done_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign cmd_valid_o   = (state != IDLE);
  assign cmd_sel_o     = sel;
  assign ack_a_o       = (state == CMD_A) && cmd_done_i;
  assign ack_b_o       = (state == CMD_B) && cmd_done_i;
  assign ref_pend_o    = pend;
  assign ref_overrun_o = ovr;

endmodule

// File: tb/tb_pkmc_sdram_access_sched.sv
// Scoreboard bench for pkmc_sdram_access_sched.
// Random traffic is scored against a behavioural scheduler model.
module tb_pkmc_sdram_access_sched;

  localparam int P    = 10;
  localparam int MP   = 4;
  localparam int LMAX = 8;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       init_done_i;
  logic       req_a_i;
  logic       req_b_i;
  logic       ack_a_o;
  logic       ack_b_o;
  logic       cmd_valid_o;
  logic [1:0] cmd_sel_o;
  logic       cmd_done_i;
  logic [2:0] ref_pend_o;
  logic       ref_overrun_o;

  pkmc_sdram_access_sched #(
    .REF_PERIOD(P),
    .MAX_PEND(MP)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .init_done_i(init_done_i),
    .req_a_i(req_a_i),
    .req_b_i(req_b_i),
    .ack_a_o(ack_a_o),
    .ack_b_o(ack_b_o),
    .cmd_valid_o(cmd_valid_o),
    .cmd_sel_o(cmd_sel_o),
    .cmd_done_i(cmd_done_i),
    .ref_pend_o(ref_pend_o),
    .ref_overrun_o(ref_overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // behavioural model state
  int  m_timer;
  int  m_pend;
  bit  m_ovr;
  bit  m_busy;
  bit  m_rr;
  int  m_sel;
  int  lat;
  bit  acked_a;
  bit  acked_b;
  int  exp_q[$];
  int  mode;
  bit  prev_valid = 1'b0;
  bit  saw_ovr    = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_timer = P - 1;
    m_pend  = 0;
    m_ovr   = 1'b0;
    m_busy  = 1'b0;
    m_rr    = 1'b0;
    m_sel   = 0;
    acked_a = 1'b0;
    acked_b = 1'b0;
    exp_q.delete();
  endtask

  task automatic grant(int s);
    m_busy = 1'b1;
    m_sel  = s;
    exp_q.push_back(s);
    lat = $urandom_range(0, LMAX);
  endtask

  // One clock edge of the scheduler, from the spec's rules.
  task automatic model_step();
    bit tick;
    bit dec;
    tick    = init_done_i && (m_timer == 0);
    dec     = m_busy && m_sel == 2 && cmd_done_i;
    acked_a = m_busy && m_sel == 0 && cmd_done_i;
    acked_b = m_busy && m_sel == 1 && cmd_done_i;
    if (m_busy) begin
      if (cmd_done_i) m_busy = 1'b0;
    end else if (init_done_i) begin
      if (m_pend == MP) grant(2);
      else if (req_a_i && req_b_i) begin
        grant(m_rr ? 1 : 0);
        m_rr = !m_rr;
      end
      else if (req_a_i) grant(0);
      else if (req_b_i) grant(1);
      else if (m_pend > 0) grant(2);
    end
    if (tick && m_pend == MP) m_ovr = 1'b1;
    if (tick && !dec) m_pend = (m_pend < MP) ? m_pend + 1 : MP;
    else if (dec && !tick) m_pend = m_pend - 1;
    if (!init_done_i || m_timer == 0) m_timer = P - 1;
    else m_timer = m_timer - 1;
  endtask

  task automatic cycle();
    @(posedge clk_i);
    if (rst_ni) model_step();
    #1;
    if (m_busy) begin
      if (lat == 0) cmd_done_i = 1'b1;
      else begin
        cmd_done_i = 1'b0;
        lat--;
      end
    end else begin
      cmd_done_i = ($urandom_range(0, 7) == 0);
    end
    case (mode)
      0: begin
        req_a_i = 1'b0;
        req_b_i = 1'b0;
      end
      2: begin
        req_a_i = 1'b1;
        req_b_i = 1'b1;
      end
      default: begin
        if (acked_a) req_a_i = ($urandom_range(0, 3) == 0);
        else if (!req_a_i) req_a_i = ($urandom_range(0, 4) == 0);
        if (acked_b) req_b_i = ($urandom_range(0, 3) == 0);
        else if (!req_b_i) req_b_i = ($urandom_range(0, 4) == 0);
      end
    endcase
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Monitor: per-cycle output checks and command-order scoreboard.
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        chk("rst_valid", cmd_valid_o, 0);
        chk("rst_sel", cmd_sel_o, 0);
        chk("rst_ack_a", ack_a_o, 0);
        chk("rst_ack_b", ack_b_o, 0);
        chk("rst_pend", ref_pend_o, 0);
        chk("rst_ovr", ref_overrun_o, 0);
      end else begin
        chk("cmd_valid", cmd_valid_o, m_busy);
        chk("ack_a", ack_a_o, m_busy && m_sel == 0 && cmd_done_i);
        chk("ack_b", ack_b_o, m_busy && m_sel == 1 && cmd_done_i);
        chk("ref_pend", ref_pend_o, m_pend);
        chk("ref_overrun", ref_overrun_o, m_ovr);
        if (cmd_valid_o && !prev_valid) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL cmd_sel unexpected command sel=%0d", cmd_sel_o);
          end else begin
            chk("cmd_sel", cmd_sel_o, exp_q.pop_front());
          end
        end
      end
      if (ref_overrun_o === 1'b1) saw_ovr = 1'b1;
      prev_valid = (cmd_valid_o === 1'b1);
    end
  end

  initial begin
    int n;
    mode        = 2;
    rst_ni      = 1'b0;
    init_done_i = 1'b0;
    req_a_i     = 1'b1;
    req_b_i     = 1'b1;
    cmd_done_i  = 1'b0;
    model_reset();
    run(4);
    rst_ni = 1'b1;

    // requests with init pending are ignored; no refresh ticks
    run(500);

    init_done_i = 1'b1;
    mode = 0;
    run(45);

    mode = 1;
    run(1500);
    init_done_i = 1'b0;
    run(30);
    init_done_i = 1'b1;
    run(1000);

    mode = 2;
    run(600);

    // asynchronous reset in the middle of a B command
    mode = 1;
    n = 0;
    while (!(m_busy && m_sel == 1) && n < 3000) begin
      cycle();
      n++;
    end
    chk("wait_cmd_b", m_busy && m_sel == 1, 1);
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("async_valid", cmd_valid_o, 0);
    chk("async_ack_b", ack_b_o, 0);
    chk("async_pend", ref_pend_o, 0);
    chk("async_ovr", ref_overrun_o, 0);
    run(3);
    rst_ni = 1'b1;
    run(400);

    mode = 0;
    run(30);
    chk("queue_drained", exp_q.size(), 0);
    chk("overrun_seen", saw_ovr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
